// File: rtl/cu_mem_arbiter.sv
// cu_mem_arbiter: round-robin arbiter sharing one SRAM port between IF reads and MEM reads/writes.
// Every access runs IDLE -> ISSUE -> (WAIT) -> RESP; all outputs are registered.
module cu_mem_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int SRAM_LAT = 1
) (
    input  logic              soc_clk,
    input  logic              soc_rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_be,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [3:0]        sram_be,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy,
    output logic              last_grant
);
    localparam int CNT_W = $clog2(SRAM_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                if_ack_q, if_ack_d;
    logic                mem_ack_q, mem_ack_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                sram_en_q, sram_en_d;
    logic                sram_we_q, sram_we_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [3:0]          sram_be_q, sram_be_d;
    logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
    logic                busy_q, busy_d;
    logic                grant_mem;
    logic                cap_we;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_ack_d     = 1'b0;
        mem_ack_d    = 1'b0;
        sram_en_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_addr_d  = '0;
        sram_be_d    = '0;
        sram_wdata_d = '0;
        grant_mem    = 1'b0;
        cap_we       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (if_req || mem_req) begin
                    // The SRAM output registers double as the captured request fields.
                    grant_mem    = mem_req && (!if_req || !last_grant_q);
                    cap_we       = grant_mem && mem_we;
                    owner_d      = grant_mem;
                    last_grant_d = grant_mem;
                    sram_en_d    = 1'b1;
                    sram_we_d    = cap_we;
                    sram_addr_d  = grant_mem ? mem_addr : if_addr;
                    sram_be_d    = cap_we ? mem_be : 4'hF;
                    sram_wdata_d = grant_mem ? mem_wdata : '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (sram_we_q) begin
                    // Only MEM can own a write.
                    mem_ack_d   = 1'b1;
                    mem_rdata_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d   = CNT_W'(SRAM_LAT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                    if (owner_q) begin
                        mem_ack_d   = 1'b1;
                        mem_rdata_d = sram_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = sram_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge soc_clk) begin
        if (!soc_rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            last_grant_q <= 1'b0;
            if_ack_q     <= 1'b0;
            mem_ack_q    <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_be_q    <= '0;
            sram_wdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            if_ack_q     <= if_ack_d;
            mem_ack_q    <= mem_ack_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_be_q    <= sram_be_d;
            sram_wdata_q <= sram_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign if_ack     = if_ack_q;
    assign if_rdata   = if_rdata_q;
    assign mem_ack    = mem_ack_q;
    assign mem_rdata  = mem_rdata_q;
    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_be    = sram_be_q;
    assign sram_wdata = sram_wdata_q;
    assign busy       = busy_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_cu_mem_arbiter.sv
// Bench for cu_mem_arbiter: a latency-1 instance with an SRAM model, plus a latency-3 instance
// whose read data encodes the cycle number so the sampling edge is visible.
module tb_cu_mem_arbiter;
    logic soc_clk   = 1'b0;
    logic soc_rst_n = 1'b0;
    always #5 soc_clk = ~soc_clk;

    int unsigned cyc = 0;
    always @(posedge soc_clk) cyc <= cyc + 1;

    logic        if_req = 1'b0;
    logic [6:0]  if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        mem_req = 1'b0;
    logic [6:0]  mem_addr = '0;
    logic [3:0]  mem_be = '0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        sram_en, sram_we;
    logic [6:0]  sram_addr;
    logic [3:0]  sram_be;
    logic [31:0] sram_wdata, sram_rdata;
    logic        busy, last_grant;

    logic        if_ack_3, mem_ack_3, sram_en_3, sram_we_3, busy_3, last_grant_3;
    logic [31:0] if_rdata_3, mem_rdata_3, sram_wdata_3, sram_rdata_3;
    logic [6:0]  sram_addr_3;
    logic [3:0]  sram_be_3;
    logic        mem_req_3 = 1'b0;
    logic [6:0]  mem_addr_3 = '0;

    cu_mem_arbiter #(.ADDR_W(7), .DATA_W(32), .SRAM_LAT(1)) dut (
        .soc_clk(soc_clk), .soc_rst_n(soc_rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_be(sram_be),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .busy(busy), .last_grant(last_grant)
    );

    cu_mem_arbiter #(.ADDR_W(7), .DATA_W(32), .SRAM_LAT(3)) dut_lat3 (
        .soc_clk(soc_clk), .soc_rst_n(soc_rst_n),
        .if_req(1'b0), .if_addr(7'h00), .if_ack(if_ack_3), .if_rdata(if_rdata_3),
        .mem_req(mem_req_3), .mem_addr(mem_addr_3), .mem_be(4'h0), .mem_we(1'b0),
        .mem_wdata(32'h0), .mem_ack(mem_ack_3), .mem_rdata(mem_rdata_3),
        .sram_en(sram_en_3), .sram_we(sram_we_3), .sram_addr(sram_addr_3), .sram_be(sram_be_3),
        .sram_wdata(sram_wdata_3), .sram_rdata(sram_rdata_3),
        .busy(busy_3), .last_grant(last_grant_3)
    );

    assign sram_rdata_3 = {16'hC0DE, cyc[15:0]};

    // Latency-1 SRAM model: data is valid only in the cycle after the issue, junk otherwise.
    logic [31:0] smem [128];
    logic [1:0]  rd_cnt = '0;
    logic [6:0]  rd_addr = '0;

    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge soc_clk) begin
        if (sram_en === 1'b1 && sram_we === 1'b1)
            smem[sram_addr] <= merge_be(smem[sram_addr], sram_wdata, sram_be);
        if (sram_en === 1'b1 && sram_we === 1'b0) begin
            rd_cnt  <= 2'd1;
            rd_addr <= sram_addr;
        end else if (rd_cnt != 0) begin
            rd_cnt <= rd_cnt - 2'd1;
        end
    end
    assign sram_rdata = (rd_cnt == 2'd1) ? smem[rd_addr] : 32'h0BAD_F00D;

    typedef struct {
        bit          is_mem;
        logic [31:0] rdata;
        int          cycle;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic exp_t mk(input bit is_mem, input logic [31:0] rdata, input int cycle);
        exp_t e;
        e.is_mem = is_mem;
        e.rdata  = rdata;
        e.cycle  = cycle;
        return e;
    endfunction

    task automatic test_reset();
        if_req = 1'b1; mem_req = 1'b1; if_addr = 7'h05; mem_addr = 7'h21;
        soc_rst_n = 1'b0;
        repeat (2) @(negedge soc_clk);
        n_cmp++;
        if ({if_ack, mem_ack, if_rdata, mem_rdata, sram_en, sram_we, sram_addr, sram_be, sram_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ack=%b/%b rdata=%h/%h en=%b we=%b addr=%h be=%h wdata=%h, want all 0",
                     if_ack, mem_ack, if_rdata, mem_rdata, sram_en, sram_we, sram_addr, sram_be, sram_wdata);
        end
        n_cmp++;
        if (busy !== 1'b0 || last_grant !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy_grant: busy=%b last_grant=%b, want 0 0", busy, last_grant);
        end
        if_req = 1'b0; mem_req = 1'b0;
        soc_rst_n = 1'b1;
        @(negedge soc_clk);
    endtask

    task automatic test_if_read();
        exp_t e;
        if_req = 1'b1; if_addr = 7'h05;
        sb.push_back(mk(1'b0, 32'hDEADBEEF, 3));
        for (int k = 1; k <= 8; k++) begin
            @(negedge soc_clk);
            n_cmp++;
            if (k == 1 && {sram_en, sram_we, sram_addr, sram_be} !== {1'b1, 1'b0, 7'h05, 4'hF}) begin
                n_err++;
                $display("FAIL if_read_issue: en=%b we=%b addr=%h be=%h, want 1 0 05 f", sram_en, sram_we, sram_addr, sram_be);
            end else if (k != 1 && {sram_en, sram_we, sram_addr, sram_be, sram_wdata} !== '0) begin
                n_err++;
                $display("FAIL if_read_sram_idle: k=%0d en=%b we=%b addr=%h be=%h wdata=%h, want all 0",
                         k, sram_en, sram_we, sram_addr, sram_be, sram_wdata);
            end
            n_cmp++;
            if (mem_ack !== 1'b0) begin
                n_err++;
                $display("FAIL if_read_mem_ack: k=%0d mem_ack=%b, want 0", k, mem_ack);
            end
            if (if_ack === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL if_read_extra_ack: k=%0d", k);
                end else begin
                    e = sb.pop_front();
                    if (e.cycle != k || if_rdata !== e.rdata) begin
                        n_err++;
                        $display("FAIL if_read_ack: cycle=%0d rdata=%h, want cycle=%0d rdata=%h", k, if_rdata, e.cycle, e.rdata);
                    end
                end
                if_req = 1'b0;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL if_read_missing_ack: %0d outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_contention();
        exp_t e;
        logic got_mem;
        logic [31:0] got_rd;
        @(negedge soc_clk);
        soc_rst_n = 1'b0;
        if_req = 1'b1; if_addr = 7'h05;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 7'h21; mem_be = 4'h0;
        @(negedge soc_clk);
        soc_rst_n = 1'b1;
        sb.push_back(mk(1'b1, 32'hCAFE0021, 3));
        sb.push_back(mk(1'b0, 32'hDEADBEEF, 7));
        sb.push_back(mk(1'b1, 32'hCAFE0021, 11));
        sb.push_back(mk(1'b0, 32'hDEADBEEF, 15));
        for (int k = 1; k <= 20; k++) begin
            @(negedge soc_clk);
            n_cmp++;
            if (if_ack === 1'b1 && mem_ack === 1'b1) begin
                n_err++;
                $display("FAIL contention_overlap: k=%0d both acks high, want at most one", k);
            end
            if (k == 1 || k == 5) begin
                n_cmp++;
                if (last_grant !== (k == 1)) begin
                    n_err++;
                    $display("FAIL contention_last_grant: k=%0d last_grant=%b, want %b", k, last_grant, (k == 1));
                end
            end
            if (if_ack === 1'b1 || mem_ack === 1'b1) begin
                got_mem = (mem_ack === 1'b1);
                got_rd  = got_mem ? mem_rdata : if_rdata;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL contention_extra_ack: k=%0d owner=%b", k, got_mem);
                end else begin
                    e = sb.pop_front();
                    if (e.is_mem !== got_mem || e.cycle != k || got_rd !== e.rdata) begin
                        n_err++;
                        $display("FAIL contention_ack: owner=%b cycle=%0d rdata=%h, want owner=%b cycle=%0d rdata=%h",
                                 got_mem, k, got_rd, e.is_mem, e.cycle, e.rdata);
                    end
                end
            end
            if (k == 15) begin
                if_req = 1'b0; mem_req = 1'b0;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL contention_missing_ack: %0d outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_mem_write();
        exp_t e;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 7'h10; mem_be = 4'b0011; mem_wdata = 32'h12345678;
        sb.push_back(mk(1'b1, 32'h0, 2));
        for (int k = 1; k <= 6; k++) begin
            @(negedge soc_clk);
            if (k == 1) begin
                n_cmp++;
                if ({sram_en, sram_we, sram_addr, sram_be, sram_wdata} !== {1'b1, 1'b1, 7'h10, 4'h3, 32'h12345678}) begin
                    n_err++;
                    $display("FAIL mem_write_issue: en=%b we=%b addr=%h be=%h wdata=%h, want 1 1 10 3 12345678",
                             sram_en, sram_we, sram_addr, sram_be, sram_wdata);
                end
                mem_wdata = 32'hFFFFFFFF; mem_be = 4'hF;
            end
            if (mem_ack === 1'b1 || if_ack === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL mem_write_extra_ack: k=%0d", k);
                end else begin
                    e = sb.pop_front();
                    if (mem_ack !== 1'b1 || if_ack !== 1'b0 || e.cycle != k || mem_rdata !== e.rdata || if_rdata !== 32'hDEADBEEF) begin
                        n_err++;
                        $display("FAIL mem_write_ack: acks=%b/%b cycle=%0d mem_rdata=%h if_rdata=%h, want 0/1 cycle=%0d 0 deadbeef",
                                 if_ack, mem_ack, k, mem_rdata, if_rdata, e.cycle);
                    end
                end
                mem_req = 1'b0; mem_we = 1'b0;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL mem_write_missing_ack: %0d outstanding, want 0", sb.size());
            sb.delete();
        end
        n_cmp++;
        if (smem[7'h10] !== 32'hAAAA5678) begin
            n_err++;
            $display("FAIL mem_write_content: sram[10]=%h, want aaaa5678", smem[7'h10]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 7'h11; mem_be = 4'h0; mem_wdata = 32'hFFFFFFFF;
        sb.push_back(mk(1'b1, 32'h0, 2));
        sb.push_back(mk(1'b1, 32'h11111111, 6));
        for (int k = 1; k <= 10; k++) begin
            @(negedge soc_clk);
            n_cmp++;
            if (sram_en !== (k == 1 || k == 4)) begin
                n_err++;
                $display("FAIL b2b_sram_en: k=%0d sram_en=%b, want %b", k, sram_en, (k == 1 || k == 4));
            end
            if (k == 1 || k == 4) begin
                n_cmp++;
                if ({sram_we, sram_addr, sram_be} !== ((k == 1) ? {1'b1, 7'h11, 4'h0} : {1'b0, 7'h11, 4'hF})) begin
                    n_err++;
                    $display("FAIL b2b_issue: k=%0d we=%b addr=%h be=%h", k, sram_we, sram_addr, sram_be);
                end
            end
            if (k == 3) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_idle_busy: busy=%b, want 0", busy);
                end
            end
            if (mem_ack === 1'b1 || if_ack === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra_ack: k=%0d", k);
                end else begin
                    e = sb.pop_front();
                    if (mem_ack !== 1'b1 || e.cycle != k || mem_rdata !== e.rdata) begin
                        n_err++;
                        $display("FAIL b2b_ack: mem_ack=%b cycle=%0d rdata=%h, want 1 cycle=%0d rdata=%h",
                                 mem_ack, k, mem_rdata, e.cycle, e.rdata);
                    end
                end
                if (sb.size() == 0) mem_req = 1'b0;
                mem_we = 1'b0;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL b2b_missing_ack: %0d outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_latency();
        exp_t e;
        int unsigned c0;
        c0 = cyc;
        mem_req_3 = 1'b1; mem_addr_3 = 7'h33;
        sb.push_back(mk(1'b1, {16'hC0DE, 16'(c0 + 4)}, 5));
        for (int k = 1; k <= 9; k++) begin
            @(negedge soc_clk);
            n_cmp++;
            if (sram_en_3 !== (k == 1) || if_ack_3 !== 1'b0) begin
                n_err++;
                $display("FAIL latency_en: k=%0d sram_en=%b if_ack=%b, want %b 0", k, sram_en_3, if_ack_3, (k == 1));
            end
            if (mem_ack_3 === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL latency_extra_ack: k=%0d", k);
                end else begin
                    e = sb.pop_front();
                    if (e.cycle != k || mem_rdata_3 !== e.rdata) begin
                        n_err++;
                        $display("FAIL latency_ack: cycle=%0d rdata=%h, want cycle=%0d rdata=%h", k, mem_rdata_3, e.cycle, e.rdata);
                    end
                end
                mem_req_3 = 1'b0;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL latency_missing_ack: %0d outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_abort();
        exp_t e;
        if_req = 1'b1; if_addr = 7'h05;
        sb.push_back(mk(1'b0, 32'hDEADBEEF, 6));
        for (int k = 1; k <= 10; k++) begin
            @(negedge soc_clk);
            if (k == 1) begin
                n_cmp++;
                if (sram_en !== 1'b1) begin
                    n_err++;
                    $display("FAIL abort_issue: sram_en=%b, want 1", sram_en);
                end
            end
            if (k == 2) soc_rst_n = 1'b0;
            if (k == 3) begin
                n_cmp++;
                if ({if_ack, mem_ack, if_rdata, mem_rdata, sram_en, sram_we, sram_addr, sram_be, sram_wdata, busy, last_grant} !== '0) begin
                    n_err++;
                    $display("FAIL abort_cleared: ack=%b/%b rdata=%h/%h en=%b busy=%b lg=%b, want all 0",
                             if_ack, mem_ack, if_rdata, mem_rdata, sram_en, busy, last_grant);
                end
                soc_rst_n = 1'b1;
            end
            if (if_ack === 1'b1 || mem_ack === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL abort_extra_ack: k=%0d", k);
                end else begin
                    e = sb.pop_front();
                    if (if_ack !== 1'b1 || e.cycle != k || if_rdata !== e.rdata) begin
                        n_err++;
                        $display("FAIL abort_reissue_ack: if_ack=%b cycle=%0d rdata=%h, want 1 cycle=%0d rdata=%h",
                                 if_ack, k, if_rdata, e.cycle, e.rdata);
                    end
                end
                if_req = 1'b0;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL abort_missing_ack: %0d outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) smem[i] = 32'h01010101 * i;
        smem[7'h05] = 32'hDEADBEEF;
        smem[7'h10] = 32'hAAAAAAAA;
        smem[7'h11] = 32'h11111111;
        smem[7'h21] = 32'hCAFE0021;

        test_reset();
        test_if_read();
        test_contention();
        test_mem_write();
        test_back_to_back();
        test_latency();
        test_abort();

        repeat (2) @(negedge soc_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cu_mem_arbiter.md
# cu_mem_arbiter

Shared-port SRAM access controller for the CU. It accepts instruction-fetch reads from the IF stage and data reads/writes from the MEM stage, and arbitrates them fairly onto the single SRAM port. It sequences each access (issue, wait for read latency, respond) and returns read data with a one-cycle acknowledge. The block sits between the CU stage logic and the SRAM/MMU interface.

## Interface
- `ADDR_W`, default 7: address width, word/byte address as used by the stages.
- `DATA_W`, default 32: data width.
- `SRAM_LAT`, default 1: cycles from the SRAM issue cycle to valid `sram_rdata`. Legal range is 1 to 7.

Ports:
- `soc_clk`, in, 1: the single clock. All logic is on its rising edge.
- `soc_rst_n`, in, 1: synchronous, active-low reset.
- `if_req`, in, 1: IF read request. Held high until `if_ack`.
- `if_addr`, in, ADDR_W: IF read address.
- `if_ack`, out, 1: one-cycle pulse that completes the IF request.
- `if_rdata`, out, DATA_W: IF read data. Valid while `if_ack` is high.
- `mem_req`, in, 1: MEM request. Held high until `mem_ack`.
- `mem_addr`, in, ADDR_W: MEM address.
- `mem_be`, in, 4: byte enables (bytes to access). Used for writes only.
- `mem_we`, in, 1: 1 means write, 0 means read.
- `mem_wdata`, in, DATA_W: MEM write data.
- `mem_ack`, out, 1: one-cycle completion pulse for the MEM request.
- `mem_rdata`, out, DATA_W: MEM read data. Valid while `mem_ack` is high. Zero for writes.
- `sram_en`, out, 1: SRAM access strobe, one cycle per access.
- `sram_we`, out, 1: SRAM write enable.
- `sram_addr`, out, ADDR_W: SRAM address.
- `sram_be`, out, 4: SRAM byte enables.
- `sram_wdata`, out, DATA_W: SRAM write data.
- `sram_rdata`, in, DATA_W: SRAM read data.
- `busy`, out, 1: high in every state except IDLE.
- `last_grant`, out, 1: owner of the most recent grant. 0 means IF, 1 means MEM.

## Operation
States: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - With no request pending, remain in IDLE.
  - With exactly one request pending, grant it.
  - With both requests pending, grant the requester that is not `last_grant` (round-robin).
  - On a grant:
    - Register the owner, address, we, be and wdata.
    - Update `last_grant`.
    - Go to ISSUE.
  - For an IF grant the captured fields are forced to we=0, be=4'hF, wdata=0.
- **ISSUE**
  - Drive `sram_en=1` with the captured fields for exactly one cycle.
  - For reads, drive `sram_be=4'hF` regardless of `mem_be`.
  - A write goes to RESP.
  - A read loads a latency counter with `SRAM_LAT` and goes to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, register `sram_rdata` into the owner's rdata register at that edge and go to RESP.
  - Counter width is `$clog2(SRAM_LAT+1)`.
- **RESP**
  - Pulse the owner's ack for one cycle. The owner's rdata register holds the captured value; writes load 0.
  - Go to IDLE.
- Outside ISSUE, all SRAM outputs are 0: `sram_en=0`, `sram_we=0`, and address, be and wdata are zero.
- Request fields are sampled only at the grant. Changes to them afterwards are ignored.
- Dropping `req` before its ack is a protocol violation. The captured transaction still completes and still acks.
- `mem_we=1` with `mem_be=0` is a legal write. It is issued with be=0 and acked normally.
- The non-owner's ack is never asserted. Its rdata register retains its last value.

## Timing
- Let cycle 0 be the cycle in which IDLE sees `req`.
  - The SRAM issue occurs in cycle 1.
  - A write acks in cycle 2.
  - A read's `sram_rdata` is sampled at the end of cycle `SRAM_LAT+1` and the ack occurs in cycle `SRAM_LAT+2` (cycle 3 when `SRAM_LAT=1`).
- IDLE is re-entered in the cycle after the ack.
- A `req` that is high in the cycle after its own ack is treated as a new request.
  - Maximum throughput is one write per 3 cycles, or one read per `SRAM_LAT+3` cycles.
- Worst-case wait under contention is one full transaction of the other requester. There is no starvation.
- **Reset values:** all outputs are 0: acks, both rdata registers, all SRAM outputs, `busy`, and `last_grant` (IF). The state is IDLE.
  - Because `last_grant` resets to IF, the first tie goes to MEM.
- **Reset mid-operation:** `soc_rst_n=0` sampled in any state aborts the access.
  - The next cycle is IDLE with all outputs 0.
  - No ack is issued for the aborted request.
  - The request re-arbitrates once reset is released if its `req` is still high.
- A request arriving during a non-IDLE state waits. It is considered only in IDLE.

## Test plan
- **Reset:** hold `soc_rst_n=0` for 2 cycles with both reqs high. All outputs must be 0, `busy=0` and `last_grant=0`.
- **IF read:** `SRAM_LAT=1`, `if_req` with addr 0x05, SRAM returns 0xDEADBEEF in cycle 2. Required response:
  - `sram_en` in cycle 1 with addr 0x05, we=0, be=F.
  - `if_ack` in cycle 3 with `if_rdata=0xDEADBEEF`.
  - `mem_ack` stays 0.
- **MEM write:** addr 0x10, be=4'b0011, wdata 0x12345678. Required response:
  - Cycle 1: `sram_we=1`, be=3, wdata 0x12345678.
  - Cycle 2: `mem_ack=1` with `mem_rdata=0`.
- **Contention:** both reqs held high continuously from reset release. Grants must alternate MEM, IF, MEM, IF. Every ack is one cycle wide. Acks never overlap.
- **Latency:** `SRAM_LAT=3`, MEM read. Required response:
  - `sram_en` in cycle 1.
  - `sram_rdata` sampled at the end of cycle 4.
  - `mem_ack` in cycle 5.
- **Abort:** assert `soc_rst_n=0` during WAIT of an IF read. Required response:
  - No `if_ack`, and the next cycle is IDLE with all outputs 0.
  - After release with `if_req` still high, the read reissues and acks normally.
